ff_excite_driver: RTL and testbench

FF_EXCITE_DRIVER -- requirements
Module: ff_excite_driver

---
 rtl/ff_exc_pkg.sv | 18 +
 rtl/ff_excite.sv | 33 +++
 rtl/ff_excite_driver.sv | 157 +++++++++++++++
 tb/tb_ff_excite_driver.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ff_exc_pkg.sv
// Shared encodings for the flip-flop excitation driver: excitation modes
// and the driver FSM states.
package ff_exc_pkg;

  typedef enum logic [1:0] {
    MODE_SR = 2'b00,
    MODE_JK = 2'b01,
    MODE_T  = 2'b10,
    MODE_D  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_APPLY = 2'b01,
    ST_CHECK = 2'b10
  } state_e;

endpackage

// File: rtl/ff_excite.sv
// Combinational excitation table: given the present Q and the desired next Q,
// produce the inputs that drive an SR, JK, T or D flip-flop to that state.
// SR and JK share one table that never requests S=R=1 (no toggle), so the
// same encoding is safe for both flip-flop kinds.
module ff_excite
  import ff_exc_pkg::*;
(
  input  logic [1:0] mode,
  input  logic       q,
  input  logic       tgt,
  output logic       s,
  output logic       r
);

  // Table lookup; T and D modes never use the second excitation line.
  always_comb begin
    s = 1'b0;
    r = 1'b0;
    case (mode_e'(mode))
      MODE_SR, MODE_JK: begin
        s = !q && tgt;
        r = q && !tgt;
      end
      MODE_T: s = q ^ tgt;
      MODE_D: s = tgt;
      default: begin
        s = 1'b0;
        r = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/ff_excite_driver.sv
// Drives an external flip-flop through a queue of target bits. Each bit is
// applied for one cycle (APPLY), the flip-flop output is checked the cycle
// after (CHECK), and failed checks are flagged and counted.
module ff_excite_driver
  import ff_exc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             tgt_valid,
  input  logic             tgt_bit,
  output logic             tgt_ready,
  output logic             s,
  output logic             r,
  input  logic             q_fb,
  input  logic             err_clr,
  output logic             busy,
  output logic             mismatch,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = AW + 1;

  state_e           state;
  mode_e            mode_q;
  logic [DEPTH-1:0] fifo_mem;
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      fill;
  logic [AW-1:0]    rd_idx;
  logic [AW-1:0]    rd_idx_nxt;
  logic             empty;
  logic             full;
  logic             ready_en;
  logic             push;
  logic             pop;
  logic             more;
  logic             head;
  logic             next_head;
  logic             apply_tgt;
  logic             apply_s;
  logic             apply_r;
  logic             hold_s;
  logic             d_hold;
  logic             enter_apply;
  logic             check_fail;

  // FIFO bookkeeping: pointers carry one extra wrap bit so full and empty
  // are distinguishable without a separate counter.
  assign fill       = wr_ptr - rd_ptr;
  assign empty      = (fill == '0);
  assign full       = (fill == PW'(DEPTH));
  assign rd_idx     = rd_ptr[AW-1:0];
  assign rd_idx_nxt = rd_idx + AW'(1);
  assign head       = fifo_mem[rd_idx];

  // ready_en keeps tgt_ready low while reset is asserted.
  assign tgt_ready = ready_en && !full;
  assign push      = tgt_valid && tgt_ready;
  assign pop       = (state == ST_CHECK);

  // When the head is popped, the next bit is either already stored behind it
  // or is arriving this very cycle; bypassing the arriving bit lets the FSM
  // go straight back to APPLY and keep a two-cycle cadence.
  assign next_head   = (fill > PW'(1)) ? fifo_mem[rd_idx_nxt] : tgt_bit;
  assign more        = (fill > PW'(1)) || push;
  assign enter_apply = ((state == ST_IDLE) && !empty) || ((state == ST_CHECK) && more);
  assign apply_tgt   = (state == ST_CHECK) ? next_head : head;

  assign check_fail = pop && (q_fb != head);
  assign hold_s     = (mode_q == MODE_D) ? d_hold : 1'b0;
  assign busy       = (state != ST_IDLE) || !empty;

  ff_excite u_excite (
    .mode (mode),
    .q    (q_fb),
    .tgt  (apply_tgt),
    .s    (apply_s),
    .r    (apply_r)
  );

  // Target-bit storage: write on accepted push, retire the head after CHECK.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fifo_mem <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr[AW-1:0]] <= tgt_bit;
        wr_ptr                   <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  // Re-enable acceptance on the first clock edge after reset is released.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
    end
  end

  // Driver FSM with registered excitation: mode and the excitation are
  // captured on entry to APPLY, then replaced by the hold value for the rest
  // of the bit's life. D mode holds the last applied target so the flop keeps
  // its value; every other mode holds with all-zero inputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      mode_q   <= MODE_SR;
      s        <= 1'b0;
      r        <= 1'b0;
      d_hold   <= 1'b0;
      mismatch <= 1'b0;
    end else begin
      mismatch <= check_fail;
      if (enter_apply) begin
        state  <= ST_APPLY;
        mode_q <= mode_e'(mode);
        s      <= apply_s;
        r      <= apply_r;
        if (mode_e'(mode) == MODE_D) begin
          d_hold <= apply_tgt;
        end
      end else if (state == ST_APPLY) begin
        state <= ST_CHECK;
        s     <= hold_s;
        r     <= 1'b0;
      end else if (state == ST_CHECK) begin
        state <= ST_IDLE;
      end else begin
        state <= ST_IDLE;
      end
    end
  end

  // Saturating error counter; an explicit clear wins over a same-cycle failure.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= '0;
    end else if (check_fail && (err_cnt != '1)) begin
      err_cnt <= err_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ff_excite_driver.sv
// Scoreboard bench for ff_excite_driver: directed target bits push their
// hand-computed excitation and feedback values into queues; a monitor pops
// and compares them whenever the driver is applying or checking a bit.
// A behavioural flip-flop closes the loop from s/r back to q_fb.
module tb_ff_excite_driver;
  import ff_exc_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       mode;
  logic             tgt_valid;
  logic             tgt_bit;
  logic             tgt_ready;
  logic             s;
  logic             r;
  logic             q_fb;
  logic             err_clr;
  logic             busy;
  logic             mismatch;
  logic [CNT_W-1:0] err_cnt;

  logic ext_q      = 1'b0;
  logic q_load     = 1'b0;
  logic q_load_val = 1'b0;
  logic q_force0   = 1'b0;

  int n_cmp    = 0;
  int n_fail   = 0;
  int mis_seen = 0;
  int mis_base;
  int k;

  logic [1:0] exp_sr_q[$];
  logic       exp_qfb_q[$];
  logic [1:0] mon_sr;
  logic       mon_q;

  // Held-valid burst: offered bits, expected ready per cycle, and the
  // excitation/feedback of the bits that are accepted (starting from q=0).
  logic       pat034[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic       rdy034[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [1:0] sr034[7]   = '{2'b10, 2'b00, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
  logic       q034[7]    = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  ff_excite_driver #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .tgt_valid (tgt_valid),
    .tgt_bit   (tgt_bit),
    .tgt_ready (tgt_ready),
    .s         (s),
    .r         (r),
    .q_fb      (q_fb),
    .err_clr   (err_clr),
    .busy      (busy),
    .mismatch  (mismatch),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  assign q_fb = q_force0 ? 1'b0 : ext_q;

  // Behavioural driven flip-flop of whichever kind the current mode selects.
  always @(posedge clk) begin
    if (q_load) begin
      ext_q <= q_load_val;
    end else begin
      case (mode)
        2'b00: if (s) ext_q <= 1'b1; else if (r) ext_q <= 1'b0;
        2'b01: if (s && r) ext_q <= ~ext_q; else if (s) ext_q <= 1'b1; else if (r) ext_q <= 1'b0;
        2'b10: if (s) ext_q <= ~ext_q;
        default: ext_q <= s;
      endcase
    end
  end

  task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  // Scoreboard monitor: APPLY cycles consume an excitation entry, CHECK
  // cycles consume a feedback entry; mismatch pulses are tallied.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (mismatch === 1'b1) mis_seen++;
      if (dut.state == ST_APPLY) begin
        if (exp_sr_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("[TB] FAIL apply_unexpected: got s/r %b%b, want no apply", s, r);
        end else begin
          mon_sr = exp_sr_q.pop_front();
          check_output("apply_sr", 8'({s, r}), 8'(mon_sr));
        end
      end
      if (dut.state == ST_CHECK) begin
        if (exp_qfb_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("[TB] FAIL check_unexpected: got q_fb %b, want no check", q_fb);
        end else begin
          mon_q = exp_qfb_q.pop_front();
          check_output("check_qfb", 8'(q_fb), 8'(mon_q));
        end
      end
    end
  end

  task automatic load_q(input logic v);
    @(negedge clk);
    q_load     = 1'b1;
    q_load_val = v;
    @(negedge clk);
    q_load = 1'b0;
  endtask

  task automatic apply_stimulus(input logic bit_v, input logic [1:0] sr_e, input logic q_e);
    int n = 0;
    @(negedge clk);
    tgt_valid = 1'b1;
    tgt_bit   = bit_v;
    while (!tgt_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!tgt_ready) begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL push_timeout: got tgt_ready 0, want 1");
    end else begin
      exp_sr_q.push_back(sr_e);
      exp_qfb_q.push_back(q_e);
    end
    @(negedge clk);
    tgt_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_output(name, 8'(busy), 8'd0);
    @(negedge clk);
  endtask

  task automatic wait_check(input string name);
    int n = 0;
    while (dut.state != ST_CHECK && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_output(name, 8'(dut.state), 8'(ST_CHECK));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst       = 1'b0;
    mode      = MODE_SR;
    tgt_valid = 1'b0;
    tgt_bit   = 1'b0;
    err_clr   = 1'b0;

    // Reset state
    load_q(1'b0);
    check_output("rst_sr",       8'({s, r}),   8'd0);
    check_output("rst_busy",     8'(busy),     8'd0);
    check_output("rst_ready",    8'(tgt_ready), 8'd0);
    check_output("rst_mismatch", 8'(mismatch), 8'd0);
    check_output("rst_err_cnt",  8'(err_cnt),  8'd0);
    rst = 1'b1;
    @(negedge clk);
    check_output("ready_after_rst", 8'(tgt_ready), 8'd1);

    // SR mode, q=0, bits 1,0,0,1
    $display("[TB] SR sequence");
    mode = MODE_SR;
    apply_stimulus(1'b1, 2'b10, 1'b1);
    apply_stimulus(1'b0, 2'b01, 1'b0);
    apply_stimulus(1'b0, 2'b00, 1'b0);
    apply_stimulus(1'b1, 2'b10, 1'b1);
    wait_idle("sr_idle");
    check_output("sr_err_cnt", 8'(err_cnt), 8'd0);

    // T mode, q=1, bits 1,0,1
    $display("[TB] T sequence");
    mode = MODE_T;
    load_q(1'b1);
    mis_base = mis_seen;
    apply_stimulus(1'b1, 2'b00, 1'b1);
    apply_stimulus(1'b0, 2'b10, 1'b0);
    apply_stimulus(1'b1, 2'b10, 1'b1);
    wait_idle("t_idle");
    check_output("t_no_mismatch", 8'(mis_seen - mis_base), 8'd0);

    // D mode: s holds the last applied target through IDLE
    $display("[TB] D hold");
    mode = MODE_D;
    apply_stimulus(1'b1, 2'b10, 1'b1);
    wait_idle("d_idle_1");
    for (int i = 0; i < 3; i++) begin
      check_output($sformatf("d_hold1_%0d", i), 8'({s, r}), 8'b10);
      @(negedge clk);
    end
    apply_stimulus(1'b0, 2'b00, 1'b0);
    wait_idle("d_idle_0");
    for (int i = 0; i < 3; i++) begin
      check_output($sformatf("d_hold0_%0d", i), 8'({s, r}), 8'b00);
      @(negedge clk);
    end

    // q_fb stuck at 0: five failures saturate the 2-bit counter, then clear
    $display("[TB] error counter");
    mode     = MODE_SR;
    q_force0 = 1'b1;
    mis_base = mis_seen;
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1'b1, 2'b10, 1'b0);
    end
    wait_idle("err_idle");
    check_output("err_pulses_5", 8'(mis_seen - mis_base), 8'd5);
    check_output("err_saturate", 8'(err_cnt), 8'd3);
    apply_stimulus(1'b1, 2'b10, 1'b0);
    wait_check("err_reach_check");
    err_clr = 1'b1;
    @(negedge clk);
    @(negedge clk);
    err_clr = 1'b0;
    check_output("err_cleared", 8'(err_cnt), 8'd0);
    check_output("err_pulses_6", 8'(mis_seen - mis_base), 8'd6);
    q_force0 = 1'b0;
    wait_idle("err_idle_2");

    // tgt_valid held for 10 cycles into a 4-deep FIFO
    $display("[TB] held valid burst");
    load_q(1'b0);
    k = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tgt_valid = 1'b1;
      tgt_bit   = pat034[i];
      check_output($sformatf("burst_ready_%0d", i), 8'(tgt_ready), 8'(rdy034[i]));
      if (rdy034[i] && k < 7) begin
        exp_sr_q.push_back(sr034[k]);
        exp_qfb_q.push_back(q034[k]);
        k++;
      end
    end
    @(negedge clk);
    tgt_valid = 1'b0;
    wait_idle("burst_idle");

    // Reset during CHECK with three bits queued
    $display("[TB] reset mid-operation");
    mis_base = mis_seen;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tgt_valid = 1'b1;
      tgt_bit   = (i == 1) ? 1'b0 : 1'b1;
      exp_sr_q.push_back((i == 0) ? 2'b10 : (i == 1) ? 2'b01 : (i == 2) ? 2'b10 : 2'b00);
      exp_qfb_q.push_back((i == 1) ? 1'b0 : 1'b1);
    end
    @(negedge clk);
    tgt_valid = 1'b0;
    wait_check("rst_reach_check");
    rst = 1'b0;
    exp_sr_q.delete();
    exp_qfb_q.delete();
    #1;
    check_output("midrst_sr",      8'({s, r}),   8'd0);
    check_output("midrst_busy",    8'(busy),     8'd0);
    check_output("midrst_ready",   8'(tgt_ready), 8'd0);
    check_output("midrst_err_cnt", 8'(err_cnt),  8'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_output("rel_ready", 8'(tgt_ready),  8'd1);
    check_output("rel_busy",  8'(busy),       8'd0);
    check_output("rel_state", 8'(dut.state),  8'(ST_IDLE));
    check_output("rel_sr",    8'({s, r}),     8'd0);
    @(negedge clk);
    @(negedge clk);
    check_output("rel_empty",       8'(busy), 8'd0);
    check_output("rel_no_mismatch", 8'(mis_seen - mis_base), 8'd0);

    // Normal operation resumes after reset
    apply_stimulus(1'b1, 2'b10, 1'b1);
    wait_idle("post_rst_idle");
    check_output("sb_drain_sr", 8'(exp_sr_q.size()),  8'd0);
    check_output("sb_drain_q",  8'(exp_qfb_q.size()), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
